fetch_queue: RTL and testbench

Instruction prefetch queue sitting between the memory controller's instruction port and fetch stage 1. It replaces stage 1's direct combinational instruction read with a request/acknowledge handshake to memory and buffers up to DEPTH fetched {pc, inst} pairs. It flushes and restarts on a taken branch. Stage 1 pops one entry per cycle when ready; decode stalls hold entries in the queue.

---
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_queue.sv | 143 ++++++++++++++
 tb/tb_fetch_queue.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Bus bundle for the instruction prefetch queue: memory request/ack port and
// the head-of-queue port toward fetch stage 1.
interface fetch_queue_if;
  // Memory side: mem_req/mem_addr hold steady until the edge that samples
  // i_mem_ack=1. Consumer side: the head entry transfers on any edge where
  // valid=1 and i_ready=1; valid/pc/inst never depend on i_ready.
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        i_ready;

  modport master (
    output mem_req, mem_addr, valid, pc, inst,
    input  i_mem_ack, i_mem_data, i_ready
  );

  modport slave (
    input  mem_req, mem_addr, valid, pc, inst,
    output i_mem_ack, i_mem_data, i_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues one outstanding memory request at a time,
// buffers up to DEPTH {pc, inst} pairs and flushes/restarts on a taken branch.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_redirect,
  input  logic [31:0]   i_redirect_pc,
  fetch_queue_if.master bus,
  output logic [1:0]    dbg_state_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic          mem_req_q, mem_req_d;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic          valid_w;
  logic          pop;
  logic          push;
  logic [CW-1:0] count_nx;
  logic          can_issue;

  assign valid_w  = (count_q != '0);
  assign pop      = valid_w & bus.i_ready & ~i_redirect;
  assign push     = (state_q == S_BUSY) & bus.i_mem_ack & ~i_redirect;
  assign count_nx = count_q + CW'(push) - CW'(pop);
  // A request only goes out when its reply is guaranteed a free slot.
  assign can_issue = (count_nx < CW'(DEPTH));

  assign bus.valid    = valid_w;
  assign bus.pc       = pc_mem[rd_ptr_q];
  assign bus.inst     = inst_mem[rd_ptr_q];
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign dbg_state_o  = state_q;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    count_d    = count_nx;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;

    if (i_redirect) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = i_redirect_pc;
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_redirect) begin
          mem_req_d  = 1'b1;
          mem_addr_d = i_redirect_pc;
          state_d    = S_BUSY;
        end else if (can_issue) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.i_mem_ack) begin
          if (i_redirect) begin
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            fetch_pc_d = mem_addr_q + 32'd4;
            if (can_issue) begin
              mem_addr_d = mem_addr_q + 32'd4;
            end else begin
              mem_req_d = 1'b0;
              state_d   = S_IDLE;
            end
          end
        end else if (i_redirect) begin
          // The old request must still complete; its data is thrown away.
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (bus.i_mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Payload storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= mem_addr_q;
      inst_mem[wr_ptr_q] <= bus.i_mem_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a latency-programmable memory responder,
// an expected-pop scoreboard with an independent monitor, and timing checks.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [1:0]  dbg_state;
  logic        ready = 1'b0;
  logic        resp_ack = 1'b0;
  logic [31:0] resp_data = 32'h0;
  logic        man_ack = 1'b0;
  logic [31:0] man_data = 32'h0;
  bit          resp_en = 1'b1;
  int          lat = 1;
  int          resp_cnt = 0;

  logic [63:0] exp_q[$];
  int          tests_run = 0;
  int          failed = 0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  always #5 clk = ~clk;

  fetch_queue_if bus();

  assign bus.i_mem_ack  = resp_ack | man_ack;
  assign bus.i_mem_data = man_ack ? man_data : resp_data;
  assign bus.i_ready    = ready;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .bus           (bus),
    .dbg_state_o   (dbg_state)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1300_0000 + a;
  endfunction

  // Memory model: ack arrives lat cycles after the request becomes visible.
  always @(posedge clk) begin
    #1;
    if (!rst_n || !resp_en) begin
      resp_ack = 1'b0;
      resp_cnt = 0;
    end else begin
      if (resp_ack) resp_cnt = 0;
      if (bus.mem_req) begin
        resp_cnt++;
        if (resp_cnt >= lat) begin
          resp_ack  = 1'b1;
          resp_data = mem_word(bus.mem_addr);
        end else begin
          resp_ack = 1'b0;
        end
      end else begin
        resp_ack = 1'b0;
        resp_cnt = 0;
      end
    end
  end

  // Monitor: every consumed head entry must match the scoreboard front.
  always @(negedge clk) begin
    if (rst_n && bus.valid && ready && !redirect) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL head_pop: got pc=%h inst=%h, required no entry", bus.pc, bus.inst);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({bus.pc, bus.inst} !== e) begin
          failed++;
          $display("FAIL head_pop: got pc=%h inst=%h, required pc=%h inst=%h",
                   bus.pc, bus.inst, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_q.push_back({a, mem_word(a)});
  endtask

  task automatic do_reset();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst_n    = 1'b0;
    ready    = 1'b0;
    redirect = 1'b0;
    man_ack  = 1'b0;
    resp_en  = 1'b1;
    @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
  endtask

  task automatic release_rst();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_addr(input logic [31:0] a, input int budget);
    bit found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      tick();
      if (bus.mem_req && bus.mem_addr == a) found = 1'b1;
    end
    check("wait_req_addr", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_req_low(input int budget);
    bit found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      tick();
      if (!bus.mem_req) found = 1'b1;
    end
    check("wait_req_low", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_budget", 32'(exp_q.size()), 32'd0);
    ready = 1'b0;
  endtask

  initial begin
    #200000;
    failed++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $fatal(1, "watchdog");
  end

  initial begin
    // Back-to-back streaming with 1-cycle ack.
    do_reset();
    lat = 1;
    release_rst();
    ready = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
    tick();
    @(negedge clk);
    check("t1_first_req", 32'(bus.mem_req), 32'd1);
    check("t1_first_addr", bus.mem_addr, 32'h0);
    check("t1_valid_e1", 32'(bus.valid), 32'd0);
    tick();
    @(negedge clk);
    check("t1_valid_e2", 32'(bus.valid), 32'd1);
    check("t1_addr_e2", bus.mem_addr, 32'h4);
    tick();
    @(negedge clk);
    check("t1_addr_e3", bus.mem_addr, 32'h8);
    wait_drain(10);

    // Fill to DEPTH, then a single pop reopens fetch on the same edge.
    do_reset();
    lat = 1;
    release_rst();
    repeat (5) tick();
    @(negedge clk);
    check("t2_full_req", 32'(bus.mem_req), 32'd0);
    check("t2_full_valid", 32'(bus.valid), 32'd1);
    check("t2_head_pc", bus.pc, 32'h0);
    check("t2_head_inst", bus.inst, mem_word(32'h0));
    repeat (3) tick();
    @(negedge clk);
    check("t2_hold_req", 32'(bus.mem_req), 32'd0);
    check("t2_hold_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    push_exp(32'h0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    @(negedge clk);
    check("t2_head_adv", bus.pc, 32'h4);
    check("t2_reopen_req", 32'(bus.mem_req), 32'd1);
    check("t2_reopen_addr", bus.mem_addr, 32'h10);
    tick();
    @(negedge clk);
    check("t2_refull_req", 32'(bus.mem_req), 32'd0);
    push_exp(32'h4); push_exp(32'h8); push_exp(32'hC); push_exp(32'h10);
    tick();
    ready = 1'b1;
    wait_drain(10);

    // Redirect while BUSY, stale ack arrives later through DISCARD.
    do_reset();
    lat = 3;
    release_rst();
    ready = 1'b1;
    push_exp(32'h0);
    wait_addr(32'h8, 20);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    push_exp(32'h100);
    push_exp(32'h104);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("t3_flush_valid", 32'(bus.valid), 32'd0);
    check("t3_discard_state", 32'(dbg_state), 32'(ST_DISCARD));
    check("t3_stale_addr", bus.mem_addr, 32'h8);
    wait_req_low(6);
    tick();
    @(negedge clk);
    check("t3_new_req", 32'(bus.mem_req), 32'd1);
    check("t3_new_addr", bus.mem_addr, 32'h100);
    wait_drain(20);

    // Redirect in the same cycle as the ack for 0xC.
    do_reset();
    lat = 1;
    release_rst();
    wait_addr(32'hC, 10);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("t4_req_gap", 32'(bus.mem_req), 32'd0);
    check("t4_flush_valid", 32'(bus.valid), 32'd0);
    tick();
    @(negedge clk);
    check("t4_new_req", 32'(bus.mem_req), 32'd1);
    check("t4_new_addr", bus.mem_addr, 32'h200);
    push_exp(32'h200);
    push_exp(32'h204);
    tick();
    ready = 1'b1;
    wait_drain(10);

    // Two redirects during DISCARD: only the last target is fetched.
    do_reset();
    lat = 3;
    release_rst();
    wait_addr(32'h4, 10);
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("t5_discard_state", 32'(dbg_state), 32'(ST_DISCARD));
    check("t5_stale_addr", bus.mem_addr, 32'h4);
    wait_req_low(6);
    tick();
    @(negedge clk);
    check("t5_new_req", 32'(bus.mem_req), 32'd1);
    check("t5_new_addr", bus.mem_addr, 32'h400);
    push_exp(32'h400);
    tick();
    ready = 1'b1;
    wait_drain(10);

    // Asynchronous reset with 3 entries and a request outstanding.
    do_reset();
    lat = 1;
    release_rst();
    wait_addr(32'hC, 10);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(bus.valid), 32'd0);
    check("t6_async_req", 32'(bus.mem_req), 32'd0);
    check("t6_async_addr", bus.mem_addr, 32'h0);
    resp_en  = 1'b0;
    man_ack  = 1'b1;
    man_data = 32'hBAD0_BAD0;
    repeat (2) tick();
    release_rst();
    tick();
    @(negedge clk);
    man_ack = 1'b0;
    resp_en = 1'b1;
    check("t6_late_ack_valid", 32'(bus.valid), 32'd0);
    check("t6_restart_req", 32'(bus.mem_req), 32'd1);
    check("t6_restart_addr", bus.mem_addr, 32'h0);
    push_exp(32'h0);
    tick();
    ready = 1'b1;
    wait_drain(10);

    check("final_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
